// File: rtl/spirxdata.sv
// SPI receive-data stage: hunts for the start token, packs block bytes into
// DW-bit memory words, then checks the trailing CRC16 and reports one status byte.
module spirxdata #(
  parameter int DW        = 32,
  parameter int AW        = 8,
  parameter int LGTIMEOUT = 12
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [3:0]    i_lgblksz,
  input  logic          i_fifo,
  output logic          o_busy,
  output logic          o_write,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  input  logic          i_ll_busy,
  output logic          o_ll_stb,
  output logic [7:0]    o_ll_byte,
  input  logic          i_ll_stb,
  input  logic [7:0]    i_ll_byte,
  output logic          o_rxvalid,
  output logic [7:0]    o_response
);
  localparam int NB = DW / 8;

  typedef enum logic [1:0] {IDLE, TOKEN, DATA, CRC} state_t;

  state_t               state;
  logic [3:0]           lgblksz;
  logic                 pending;
  logic [LGTIMEOUT-1:0] tcount;
  logic [9:0]           byte_cnt;
  logic [DW-1:0]        sreg;
  logic [15:0]          crc;
  logic [7:0]           crc_hi;

  logic                 rx, fin, go_next, word_done, last_byte;
  logic [7:0]           fin_resp;
  logic [DW-1:0]        next_word;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  assign o_ll_byte = 8'hff;
  // A received byte only counts when it answers our own outstanding request
  assign rx        = pending && i_ll_stb;
  assign next_word = (sreg << 8) | DW'(i_ll_byte);
  assign word_done = (byte_cnt & 10'(NB - 1)) == 10'(NB - 1);
  assign last_byte = byte_cnt == ((10'd1 << lgblksz) - 10'd1);

  always_comb begin
    fin      = 1'b0;
    fin_resp = 8'h40;
    if (rx) begin
      case (state)
        TOKEN:
          if (i_ll_byte == 8'hff) begin
            if (&tcount) fin = 1'b1;
          end else if (i_ll_byte != 8'hfe) begin
            fin = 1'b1;
            if (i_ll_byte[7:4] == 4'h0) fin_resp = i_ll_byte;
          end
        CRC:
          if (byte_cnt[0]) begin
            fin      = 1'b1;
            fin_resp = ({crc_hi, i_ll_byte} == crc) ? 8'h00 : 8'h80;
          end
        default: ;
      endcase
    end
  end

  assign go_next = rx && !fin && (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      o_busy     <= 1'b0;
      o_write    <= 1'b0;
      o_ll_stb   <= 1'b0;
      o_rxvalid  <= 1'b0;
      o_addr     <= '0;
      o_data     <= '0;
      o_response <= 8'h00;
      lgblksz    <= 4'd0;
      pending    <= 1'b0;
      tcount     <= '0;
      byte_cnt   <= '0;
      sreg       <= '0;
      crc        <= 16'h0000;
      crc_hi     <= 8'h00;
    end else begin
      o_write   <= 1'b0;
      o_rxvalid <= 1'b0;
      if (o_write) o_addr[AW-2:0] <= o_addr[AW-2:0] + 1'b1;
      if (o_ll_stb && !i_ll_busy) begin
        o_ll_stb <= 1'b0;
        pending  <= 1'b1;
      end
      if (rx) pending <= 1'b0;
      if (go_next) o_ll_stb <= 1'b1;

      case (state)
        IDLE:
          if (i_start) begin
            lgblksz  <= i_lgblksz;
            o_addr   <= {i_fifo, {(AW-1){1'b0}}};
            o_busy   <= 1'b1;
            crc      <= 16'h0000;
            tcount   <= '0;
            byte_cnt <= '0;
            o_ll_stb <= 1'b1;
            state    <= TOKEN;
          end
        TOKEN:
          if (rx) begin
            if (i_ll_byte == 8'hff) tcount <= tcount + 1'b1;
            else if (i_ll_byte == 8'hfe) state <= DATA;
          end
        DATA:
          if (rx) begin
            sreg     <= next_word;
            crc      <= crc_byte(crc, i_ll_byte);
            byte_cnt <= byte_cnt + 10'd1;
            if (word_done) begin
              o_write <= 1'b1;
              o_data  <= next_word;
            end
            if (last_byte) begin
              byte_cnt <= '0;
              state    <= CRC;
            end
          end
        CRC:
          if (rx && !byte_cnt[0]) begin
            crc_hi   <= i_ll_byte;
            byte_cnt <= 10'd1;
          end
        default: state <= IDLE;
      endcase

      if (fin) begin
        state      <= IDLE;
        o_busy     <= 1'b0;
        o_rxvalid  <= 1'b1;
        o_response <= fin_resp;
      end
    end
  end
endmodule
